eth_tx_pacer: RTL
=================

# eth_tx_pacer

Parametrised transmit pacing and PHY bring-up controller for the RGMII Ethernet TX path. It sequences the PHY hardware reset and selects TX speed from debounced link-status flags. It generates the per-byte advance strobe at 1000/100/10 Mb/s rates and enforces a configurable inter-frame gap (IFG) between frames through a request/grant handshake. It sits between the frame sequencing logic and the byte generator, in the 125 MHz TX domain.

## Interface
- RST_HOLD, 8388608: cycles eth_rst_b is held low after reset or soft reset
- RST_SETTLE, 125000: cycles after eth_rst_b rises before phy_ready asserts
- CNT_W, 25: width of the reset/settle counter; must hold max(RST_HOLD, RST_SETTLE)
- DIV_100, 10: clock cycles per byte strobe at 100 Mb/s
- DIV_10, 100: clock cycles per byte strobe at 10 Mb/s
- IFG_BYTES, 12: advance strobes of idle enforced after each frame
- STABLE_CYC, 1024: cycles a decoded link speed must be stable before it is accepted
- DEFAULT_SPEED, 2'b11: speed value after reset
- clk125MHz  in  1  TX clock
- rstn  in  1  asynchronous, active-low reset
- soft_rst  in  1  synchronous, active-high; restarts PHY reset sequence
- link_10mb, link_100mb, link_1000mb  in  1 each  link flags, eth_rxck domain (asynchronous here)
- start_req  in  1  level; frame source wants to send
- frame_done  in  1  one-cycle pulse when the byte generator has advanced its last byte
- eth_rst_b  out  1  PHY reset, active low
- phy_ready  out  1  PHY reset sequence complete
- speed  out  2  11=1000, 10=100, 01=10, 00=no link
- adv_data  out  1  byte advance strobe
- start_grant  out  1  one-cycle frame start grant
- busy  out  1  high whenever state is not IDLE

## Operation
- States: RESET_HOLD, PHY_SETTLE, IDLE, FRAME, GAP.
- RESET_HOLD: the counter runs 0..RST_HOLD-1. At the terminal count: eth_rst_b<=1, counter<=0, go to PHY_SETTLE.
- PHY_SETTLE: the counter runs 0..RST_SETTLE-1. At the terminal count: phy_ready<=1, go to IDLE.
- IDLE: if start_req=1 and speed≠00, then start_grant<=1 for one cycle and go to FRAME. Holding start_req high yields exactly one grant per IDLE entry.
- FRAME: on frame_done, clear gap_cnt and go to GAP.
- GAP: each cycle with adv_data=1 increments gap_cnt. When adv_data=1 and gap_cnt==IFG_BYTES-1, go to IDLE.
- frame_done outside FRAME is ignored. start_req outside IDLE is ignored.
- soft_rst has priority over all transitions. It forces RESET_HOLD with eth_rst_b=0, phy_ready=0, start_grant=0, and counters cleared. speed is retained.
- Link synchroniser: each link flag passes through a 2-flop synchroniser.
- Link decode: priority 1000 > 100 > 10 > none, producing a 2-bit code.
- Debounce: a candidate register plus a stable counter. If the decoded code differs from the candidate, the candidate takes the code and the counter clears; otherwise the counter increments, saturating at STABLE_CYC-1.
- Speed update: speed takes the candidate when the counter is at STABLE_CYC-1, candidate≠speed, and state ∉ {FRAME, GAP}. Otherwise the change is deferred until that condition holds.
- Divider: div_cnt counts modulo N, with N=1 at speed 11, DIV_100 at 10, and DIV_10 at 01. div_cnt<=0 on every speed update.
- adv_data is registered: adv_data = (div_cnt==0) && speed≠00. At speed 11 it is constantly 1; at speed 00 it is constantly 0.

## Timing
- Reset values: eth_rst_b=0, phy_ready=0, speed=DEFAULT_SPEED, adv_data=0, start_grant=0, busy=1. State=RESET_HOLD; all counters 0.
- eth_rst_b rises RST_HOLD cycles after rstn deassertion. phy_ready rises RST_SETTLE cycles after that.
- start_grant is high during the first FRAME cycle, one cycle after IDLE samples start_req=1.
- At 1 Gb with frame_done in cycle N: GAP occupies N+1..N+12, IDLE is cycle N+13, and with start_req held the grant is high in N+14.
- Link change to speed update latency is 2 synchroniser cycles + STABLE_CYC cycles, provided the state allows it.
- Asserting rstn mid-frame aborts immediately and asynchronously: all outputs return to their reset values.

## Test plan
- Reset sequence, RST_HOLD=16, RST_SETTLE=8: release rstn at cycle 0 -> eth_rst_b=1 from cycle 16, phy_ready=1 and busy=0 from cycle 24.
- Debounce, STABLE_CYC=16: drop link_1000mb and raise link_100mb for 10 cycles then restore -> speed stays 11. Hold link_100mb alone for 20 cycles -> speed=10, then adv_data high every 10th cycle.
- IFG at 1 Gb: start_req held, frame_done pulsed in cycle N -> start_grant high in cycle N+14 only; busy low only in cycle N+13.
- Deferred speed change: the link moves to 10 Mb/s during FRAME -> speed stays 11 through FRAME and GAP, becomes 01 after the return to IDLE, and adv_data then has a period of 100.
- soft_rst during FRAME -> eth_rst_b=0 and phy_ready=0 next cycle, no grant until the RST_HOLD+RST_SETTLE sequence completes, later frame_done ignored.
- No link: all link flags low for STABLE_CYC cycles, start_req high -> speed=00, adv_data=0, and start_grant is never asserted.

Source files
------------

// File: rtl/eth_tx_pacer.sv
// RGMII TX pacing and PHY bring-up controller: sequences the PHY reset, debounces
// link speed, generates the per-byte advance strobe and enforces the inter-frame gap.
module eth_tx_pacer #(
    parameter int unsigned RST_HOLD      = 8388608,
    parameter int unsigned RST_SETTLE    = 125000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned DIV_100       = 10,
    parameter int unsigned DIV_10        = 100,
    parameter int unsigned IFG_BYTES     = 12,
    parameter int unsigned STABLE_CYC    = 1024,
    parameter logic [1:0]  DEFAULT_SPEED = 2'b11
) (
    input  logic       clk125MHz,
    input  logic       rstn,
    input  logic       soft_rst,
    input  logic       link_10mb,
    input  logic       link_100mb,
    input  logic       link_1000mb,
    input  logic       start_req,
    input  logic       frame_done,
    output logic       eth_rst_b,
    output logic       phy_ready,
    output logic [1:0] speed,
    output logic       adv_data,
    output logic       start_grant,
    output logic       busy
);

    localparam int unsigned GAP_W   = $clog2(IFG_BYTES) + 1;
    localparam int unsigned STB_W   = $clog2(STABLE_CYC) + 1;
    localparam int unsigned DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RST_SETTLE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(IFG_BYTES - 1);
    localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV100_LAST = DIV_W'(DIV_100 - 1);
    localparam logic [DIV_W-1:0] DIV10_LAST  = DIV_W'(DIV_10 - 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_PHY_SETTLE,
        S_IDLE,
        S_FRAME,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             eth_rst_b_q, eth_rst_b_d;
    logic             phy_ready_q, phy_ready_d;
    logic             grant_q, grant_d;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [1:0]       cand_q, cand_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [1:0]       speed_q, speed_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             adv_q, adv_d;

    logic [1:0]       link_code;
    logic             speed_upd;
    logic [DIV_W-1:0] div_last;

    // Link path: synchronise, priority-decode, debounce, then commit between frames.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sync1_d = {link_1000mb, link_100mb, link_10mb};
        sync2_d = sync1_q;

        if (sync2_q[2])      link_code = 2'b11;
        else if (sync2_q[1]) link_code = 2'b10;
        else if (sync2_q[0]) link_code = 2'b01;
        else                 link_code = 2'b00;

        cand_d   = cand_q;
        stable_d = stable_q;
        if (link_code != cand_q) begin
            cand_d   = link_code;
            stable_d = '0;
        end else if (stable_q != STABLE_LAST) begin
            stable_d = stable_q + 1'b1;
        end

        speed_upd = (stable_q == STABLE_LAST) && (cand_q != speed_q) &&
                    (state_q != S_FRAME) && (state_q != S_GAP);
        speed_d   = speed_upd ? cand_q : speed_q;

        case (speed_q)
            2'b10:   div_last = DIV100_LAST;
            2'b01:   div_last = DIV10_LAST;
            default: div_last = '0;
        endcase

        if (speed_upd || div_q >= div_last) div_d = '0;
        else                                div_d = div_q + 1'b1;

        adv_d = (div_q == '0) && (speed_q != 2'b00);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_cnt_d   = gap_cnt_q;
        eth_rst_b_d = eth_rst_b_q;
        phy_ready_d = phy_ready_q;
        grant_d     = 1'b0;

        case (state_q)
            S_RESET_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    eth_rst_b_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_PHY_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PHY_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    phy_ready_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (start_req && speed_q != 2'b00) begin
                    grant_d = 1'b1;
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (frame_done) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (adv_q) begin
                    if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                    else                       gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_RESET_HOLD;
        endcase

        // Soft reset restarts the PHY sequence but leaves the link speed alone.
        if (soft_rst) begin
            state_d     = S_RESET_HOLD;
            cnt_d       = '0;
            gap_cnt_d   = '0;
            eth_rst_b_d = 1'b0;
            phy_ready_d = 1'b0;
            grant_d     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RESET_HOLD;
            cnt_q       <= '0;
            gap_cnt_q   <= '0;
            eth_rst_b_q <= 1'b0;
            phy_ready_q <= 1'b0;
            grant_q     <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= DEFAULT_SPEED;
            stable_q    <= '0;
            speed_q     <= DEFAULT_SPEED;
            div_q       <= '0;
            adv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            eth_rst_b_q <= eth_rst_b_d;
            phy_ready_q <= phy_ready_d;
            grant_q     <= grant_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            speed_q     <= speed_d;
            div_q       <= div_d;
            adv_q       <= adv_d;
        end
    end

    assign eth_rst_b   = eth_rst_b_q;
    assign phy_ready   = phy_ready_q;
    assign speed       = speed_q;
    assign adv_data    = adv_q;
    assign start_grant = grant_q;
    assign busy        = (state_q != S_IDLE);

endmodule
